// File: rtl/fifo_link_pkg.sv
// Shared definitions for the master/FIFO/slave link: default word width,
// the slave's read-side state encoding and the sequence checker's start value.
package fifo_link_pkg;

  // Default FIFO word width, shared by master data_in and slave data_out.
  localparam int DATA_W_DEF = 8;

  // First word the master emits after reset; the slave's checker expects it first.
  localparam logic [DATA_W_DEF-1:0] SEQ_START_DEF = 8'h00;

  // Read-side handshake states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2,
    S_HOLD  = 2'd3
  } fifo_state_t;

endpackage

// File: rtl/fifo_slave_seq_chk.sv
// Sequence checker for fifo_slave: tracks the next word the master's
// incrementing stream should deliver and flags any captured word that
// differs. The flag is sticky until reset; the expectation always follows
// the last captured word, so one bad word raises exactly one discontinuity.
module fifo_slave_seq_chk
  import fifo_link_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SEQ_START = SEQ_START_DEF
) (
  input  logic              clk_slave,
  input  logic              reset,
  input  logic              capture,
  input  logic [DATA_W-1:0] data_out,
  output logic              seq_err
);

  logic [DATA_W-1:0] expected;

  // Compare each captured word against the expectation, then resync to word+1.
  always_ff @(posedge clk_slave) begin
    if (!reset) begin
      expected <= SEQ_START;
      seq_err  <= 1'b0;
    end else if (capture) begin
      expected <= data_out + 1'b1;
      if (data_out != expected) begin
        seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_slave.sv
// Consumer end of the master/FIFO link. Pops one word at a time from the
// shared FIFO, holds it on rx_data/rx_valid until downstream takes it, and
// keeps a running word count and modular checksum of everything captured.
// Optional build macro FIFO_SLAVE_SEQ_CHECK_EN adds the seq_err output and a
// checker that the popped stream is the master's incrementing sequence.
module fifo_slave
  import fifo_link_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                CNT_W     = 16
`ifdef FIFO_SLAVE_SEQ_CHECK_EN
  ,
  parameter logic [DATA_W-1:0] SEQ_START = SEQ_START_DEF
`endif
) (
  input  logic              clk_slave,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] data_out,
  output logic              rd_en_slave,
  input  logic              consume_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  rx_count,
  output logic [DATA_W-1:0] rx_checksum
`ifdef FIFO_SLAVE_SEQ_CHECK_EN
  ,
  output logic              seq_err
`endif
);

  fifo_state_t state;

  // Read handshake: pop one word, capture it a cycle later, hold until consumed.
  // Only one pop is ever in flight, so the FIFO cannot be over-read, and
  // fifo_empty is only looked at while idle.
  always_ff @(posedge clk_slave) begin
    if (!reset) begin
      state       <= S_IDLE;
      rd_en_slave <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_count    <= '0;
      rx_checksum <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            rd_en_slave <= 1'b1;
            state       <= S_READ;
          end
        end
        S_READ: begin
          rd_en_slave <= 1'b0;
          state       <= S_LATCH;
        end
        S_LATCH: begin
          rx_data     <= data_out;
          rx_valid    <= 1'b1;
          rx_count    <= rx_count + 1'b1;
          rx_checksum <= rx_checksum + data_out;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (consume_ready) begin
            rx_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          rd_en_slave <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_SLAVE_SEQ_CHECK_EN
  logic capture;

  // The checker samples data_out on the same edge that loads rx_data.
  assign capture = (state == S_LATCH);

  fifo_slave_seq_chk #(
    .DATA_W    (DATA_W),
    .SEQ_START (SEQ_START)
  ) u_seq_chk (
    .clk_slave (clk_slave),
    .reset     (reset),
    .capture   (capture),
    .data_out  (data_out),
    .seq_err   (seq_err)
  );
`endif

endmodule

// File: tb/tb_fifo_slave.sv
// Directed bench for fifo_slave with a behavioural FIFO and a word scoreboard.
// Words are queued into the FIFO model and the scoreboard together; each
// rising rx_valid pops the scoreboard and compares rx_data.
module tb_fifo_slave;

  localparam int DATA_W = fifo_link_pkg::DATA_W_DEF;
  localparam int CNT_W  = 16;

  logic              clk_slave     = 1'b0;
  logic              reset         = 1'b0;
  logic              fifo_empty    = 1'b1;
  logic [DATA_W-1:0] data_out      = '0;
  logic              consume_ready = 1'b0;
  logic              rd_en_slave;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [CNT_W-1:0]  rx_count;
  logic [DATA_W-1:0] rx_checksum;
`ifdef FIFO_SLAVE_SEQ_CHECK_EN
  logic              seq_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] dropped_word;
  logic              prev_valid = 1'b0;
  logic              saw_word;

  always #5 clk_slave = ~clk_slave;

  fifo_slave #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_slave     (clk_slave),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .data_out      (data_out),
    .rd_en_slave   (rd_en_slave),
    .consume_ready (consume_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_count      (rx_count),
    .rx_checksum   (rx_checksum)
`ifdef FIFO_SLAVE_SEQ_CHECK_EN
    ,
    .seq_err       (seq_err)
`endif
  );

  // Behavioural FIFO: a pop strobe presents the head word well before the capture edge.
  always @(negedge clk_slave) begin
    if (rd_en_slave === 1'b1 && fifo_q.size() > 0) begin
      data_out = fifo_q.pop_front();
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  // Scoreboard monitor: every new rx_valid must carry the oldest outstanding word.
  always @(negedge clk_slave) begin
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL capture_unexpected observed=%0h expected=none", rx_data);
      end else begin
        exp_word = exp_q.pop_front();
        checks++;
        assert (rx_data === exp_word) else begin
          errors++;
          $error("[TB] FAIL capture_data observed=%0h expected=%0h", rx_data, exp_word);
        end
      end
    end
    prev_valid = rx_valid;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [DATA_W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic wait_pop(input string tag);
    int n = 0;
    while (rd_en_slave !== 1'b1 && n < 50) begin
      @(negedge clk_slave);
      n++;
    end
    if (rd_en_slave !== 1'b1) timeout_fail(tag);
  endtask

  task automatic wait_capture(input string tag);
    int n = 0;
    while (rx_valid === 1'b1 && n < 50) begin
      @(negedge clk_slave);
      n++;
    end
    while (rx_valid !== 1'b1 && n < 100) begin
      @(negedge clk_slave);
      n++;
    end
    if (rx_valid !== 1'b1) timeout_fail(tag);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || rx_valid === 1'b1) && n < budget) begin
      @(negedge clk_slave);
      n++;
    end
    if (exp_q.size() != 0 || rx_valid === 1'b1) timeout_fail(tag);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(negedge clk_slave);
    reset = 1'b1;
  endtask

  // Global time limit so a stuck handshake still ends the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with a word waiting: no pop may start.
    consume_ready = 1'b1;
    reset         = 1'b0;
    apply_stimulus(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_slave);
      check_output("reset_rd_en", rd_en_slave, 0);
      check_output("reset_rx_valid", rx_valid, 0);
      check_output("reset_rx_count", rx_count, 0);
      check_output("reset_rx_checksum", rx_checksum, 0);
    end
    check_output("reset_rx_data", rx_data, 0);
`ifdef FIFO_SLAVE_SEQ_CHECK_EN
    check_output("reset_seq_err", seq_err, 0);
`endif

    // Single word: pop one cycle after release, capture two cycles later.
    reset = 1'b1;
    @(negedge clk_slave);
    check_output("first_pop", rd_en_slave, 1);
    @(negedge clk_slave);
    check_output("pop_width", rd_en_slave, 0);
    check_output("valid_latency", rx_valid, 0);
    @(negedge clk_slave);
    check_output("single_valid", rx_valid, 1);
    check_output("single_data", rx_data, 8'hA5);
    check_output("single_count", rx_count, 1);
    check_output("single_checksum", rx_checksum, 8'hA5);
    @(negedge clk_slave);
    check_output("single_valid_drop", rx_valid, 0);
    check_output("single_count_hold", rx_count, 1);

    // Backpressure: word held, no further pops while downstream stalls.
    consume_ready = 1'b0;
    apply_stimulus(8'hB1);
    apply_stimulus(8'hB2);
    wait_capture("bp_capture");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_slave);
      check_output("bp_valid_held", rx_valid, 1);
      check_output("bp_data_stable", rx_data, 8'hB1);
      check_output("bp_no_pop", rd_en_slave, 0);
    end
    consume_ready = 1'b1;
    @(negedge clk_slave);
    check_output("bp_release", rx_valid, 0);
    check_output("bp_idle_no_pop", rd_en_slave, 0);
    @(negedge clk_slave);
    check_output("bp_next_pop", rd_en_slave, 1);
    wait_drain("bp_drain", 50);
    check_output("bp_count", rx_count, 3);
    check_output("bp_checksum", rx_checksum, 8'h08);

    // Stream of 260 words across the FF->00 wrap.
    do_reset(2);
    @(negedge clk_slave);
    check_output("stream_reset_count", rx_count, 0);
    for (int i = 0; i < 260; i++) begin
      apply_stimulus(DATA_W'(i));
    end
    wait_drain("stream_drain", 1500);
    check_output("stream_count", rx_count, 260);
    check_output("stream_checksum", rx_checksum, 8'h86);
`ifdef FIFO_SLAVE_SEQ_CHECK_EN
    check_output("stream_seq_err", seq_err, 0);

    // Mismatch: 05 breaks the sequence, 06 resyncs, the flag stays set.
    do_reset(2);
    apply_stimulus(8'h00);
    apply_stimulus(8'h01);
    apply_stimulus(8'h05);
    apply_stimulus(8'h06);
    wait_capture("mm_cap0");
    check_output("mm_seq_err_00", seq_err, 0);
    wait_capture("mm_cap1");
    check_output("mm_seq_err_01", seq_err, 0);
    wait_capture("mm_cap2");
    check_output("mm_seq_err_05", seq_err, 1);
    wait_capture("mm_cap3");
    check_output("mm_seq_err_06", seq_err, 1);
    wait_drain("mm_drain", 50);
    check_output("mm_seq_err_sticky", seq_err, 1);
    do_reset(2);
    check_output("mm_seq_err_cleared", seq_err, 0);
`endif

    // Reset while the popped word is about to be latched: it must vanish.
    consume_ready = 1'b1;
    apply_stimulus(8'h3C);
    wait_pop("midop_pop");
    @(negedge clk_slave);
    reset        = 1'b0;
    dropped_word = exp_q.pop_front();
    @(negedge clk_slave);
    check_output("midop_rd_en", rd_en_slave, 0);
    check_output("midop_rx_valid", rx_valid, 0);
    check_output("midop_rx_count", rx_count, 0);
    check_output("midop_rx_checksum", rx_checksum, 0);
    check_output("midop_rx_data", rx_data, 0);
`ifdef FIFO_SLAVE_SEQ_CHECK_EN
    check_output("midop_seq_err", seq_err, 0);
`endif
    reset    = 1'b1;
    saw_word = 1'b0;
    repeat (6) begin
      @(negedge clk_slave);
      if (rx_valid === 1'b1 || rx_data === dropped_word) saw_word = 1'b1;
    end
    check_output("midop_word_discarded", saw_word, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
